// File: rtl/fp_chk_pkg.sv
// rtl/fp_chk_pkg.sv - float field widths, checker state and result compare (FP_CHK_ULP_TOL_EN selects 1-ULP tolerance)
package fp_chk_pkg;

  localparam int SIGN_W = 1;
  localparam int EXP_W  = 8;
  localparam int MANT_W = 18;
  localparam int FP_W   = SIGN_W + EXP_W + MANT_W;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } chk_state_t;

  // Operands arrive zero-extended to 64 bits; w is the live float width.
  function automatic logic fp_match(input logic [63:0] a, input logic [63:0] b, input int w);
`ifdef FP_CHK_ULP_TOL_EN
    logic [63:0] mag_mask;
    logic [63:0] mag_a;
    logic [63:0] mag_b;
    logic [63:0] diff;
    logic        sign_eq;
    mag_mask = (64'd1 << (w - 1)) - 64'd1;
    sign_eq  = (((a ^ b) >> (w - 1)) & 64'd1) == 64'd0;
    mag_a    = a & mag_mask;
    mag_b    = b & mag_mask;
    diff     = (mag_a > mag_b) ? (mag_a - mag_b) : (mag_b - mag_a);
    return sign_eq && (diff <= 64'd1);
`else
    logic [63:0] mask;
    mask = ~64'd0 >> (64 - w);
    return ((a ^ b) & mask) == 64'd0;
`endif
  endfunction

endpackage

// File: rtl/fp_chk_fifo.sv
// rtl/fp_chk_fifo.sv - show-ahead synchronous FIFO of expected sums with flush
module fp_chk_fifo #(
  parameter int WIDTH = 27,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Extra pointer bit distinguishes full from empty when the indices coincide.
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign head    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/fp_sum_checker.sv
// rtl/fp_sum_checker.sv - compares adder sums against queued expected sums (FP_CHK_ULP_TOL_EN: 1-ULP tolerance)
module fp_sum_checker
  import fp_chk_pkg::*;
#(
  parameter int WIDTH = FP_W,
  parameter int DEPTH = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] total,
  input  logic             exp_valid,
  output logic             exp_ready,
  input  logic [WIDTH-1:0] exp_data,
  input  logic             res_valid,
  input  logic [WIDTH-1:0] res_data,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic [CNT_W-1:0] first_fail_idx,
  output logic [WIDTH-1:0] first_fail_exp,
  output logic [WIDTH-1:0] first_fail_got,
  output logic             fail_seen,
  output logic             done,
  output logic             underflow
);

  chk_state_t       state;
  logic [CNT_W-1:0] total_q;
  logic             fifo_full;
  logic             fifo_empty;
  logic [WIDTH-1:0] head;
  logic             in_run;
  logic             start_ok;
  logic             push;
  logic             pop;
  logic             is_match;
  logic [CNT_W:0]   seen;
  logic [CNT_W:0]   seen_next;

  assign in_run    = (state == ST_RUN);
  assign start_ok  = start && !in_run;
  assign exp_ready = in_run && !fifo_full;
  assign push      = exp_valid && exp_ready;
  // The head is compared before this cycle's push lands, so no bypass exists.
  assign pop       = in_run && res_valid && !fifo_empty;
  assign is_match  = fp_match(64'(head), 64'(res_data), WIDTH);
  assign seen      = {1'b0, pass_cnt} + {1'b0, fail_cnt};
  assign seen_next = seen + 1'b1;

  fp_chk_fifo #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .flush    (start_ok),
    .push     (push),
    .push_data(exp_data),
    .pop      (pop),
    .head     (head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= ST_IDLE;
      total_q        <= '0;
      pass_cnt       <= '0;
      fail_cnt       <= '0;
      first_fail_idx <= '0;
      first_fail_exp <= '0;
      first_fail_got <= '0;
      fail_seen      <= 1'b0;
      done           <= 1'b0;
      underflow      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            total_q        <= total;
            pass_cnt       <= '0;
            fail_cnt       <= '0;
            first_fail_idx <= '0;
            first_fail_exp <= '0;
            first_fail_got <= '0;
            fail_seen      <= 1'b0;
            underflow      <= 1'b0;
            if (total == '0) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end else begin
              state <= ST_RUN;
              done  <= 1'b0;
            end
          end
        end
        ST_RUN: begin
          if (res_valid) begin
            if (fifo_empty) begin
              underflow <= 1'b1;
            end else begin
              if (is_match) begin
                if (pass_cnt != '1) pass_cnt <= pass_cnt + 1'b1;
              end else begin
                if (fail_cnt != '1) fail_cnt <= fail_cnt + 1'b1;
                if (!fail_seen) begin
                  fail_seen      <= 1'b1;
                  first_fail_idx <= seen[CNT_W-1:0];
                  first_fail_exp <= head;
                  first_fail_got <= res_data;
                end
              end
              // done rises together with the final counter value.
              if (seen_next == {1'b0, total_q}) begin
                state <= ST_DONE;
                done  <= 1'b1;
              end
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/fp_sum_checker.md
FP_SUM_CHECKER -- requirements
Module: fp_sum_checker

Interface
REQ-001 SHALL have parameter WIDTH, default 27, operand/result float width (1 sign, 8 exponent, 18 mantissa).
REQ-002 SHALL have parameter DEPTH, default 16, expected-value FIFO entries, power of two.
REQ-003 SHALL have parameter CNT_W, default 16, width of all counters and indices.
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port start  input  1  one-cycle pulse, begin a checking run.
REQ-007 SHALL have port total  input  CNT_W  results expected in the run, sampled on start.
REQ-008 SHALL have ports exp_valid input 1, exp_ready output 1, exp_data input WIDTH: expected-sum stream, transfer when both valid and ready high.
REQ-009 SHALL have ports res_valid input 1, res_data input WIDTH: adder sum stream, no backpressure.
REQ-010 SHALL have outputs pass_cnt, fail_cnt, first_fail_idx (CNT_W each): run statistics.
REQ-011 SHALL have outputs first_fail_exp, first_fail_got (WIDTH each): operands of first mismatch.
REQ-012 SHALL have outputs fail_seen, done, underflow (1 each): sticky status.

Function
REQ-013 SHALL implement FSM IDLE -> RUN on start; RUN -> DONE when pass_cnt+fail_cnt reaches total; DONE -> RUN on start; any state -> IDLE on rst.
REQ-014 SHALL, on start (IDLE or DONE), clear counters, first_fail_*, fail_seen, done, underflow, and flush the FIFO; start in RUN SHALL be ignored.
REQ-015 SHALL, on start with total = 0, go directly to DONE next cycle with all counters zero.
REQ-016 SHALL drive exp_ready = 1 only in RUN with FIFO not full; simultaneous push and pop on a full FIFO SHALL NOT be accepted (ready low).
REQ-017 SHALL, on res_valid in RUN with FIFO non-empty, pop the head and compare against res_data; no same-cycle bypass of an incoming exp_data.
REQ-018 SHALL register results one cycle after res_valid: pass_cnt or fail_cnt increments by exactly one.
REQ-019 SHALL, on the first mismatch of a run, capture first_fail_idx = result ordinal (0-based), first_fail_exp, first_fail_got, and set fail_seen; later mismatches SHALL NOT overwrite.
REQ-020 SHALL, on res_valid with FIFO empty, set underflow, count nothing, and stay in RUN.
REQ-021 SHALL ignore res_valid and exp_valid outside RUN.
REQ-022 SHALL assert done in the same cycle the final counter value is visible and hold it until start or rst.
REQ-023 SHALL treat comparison as exact bitwise equality of all WIDTH bits (default build).
REQ-024 SHALL saturate counters at all-ones rather than wrap.

Reset
REQ-025 SHALL, on rst, force IDLE, FIFO empty, exp_ready 0, all counters, captures and status outputs 0, asynchronously.

Configuration
REQ-026 SHALL, with FP_CHK_ULP_TOL_EN defined, count a result as pass when sign bits match and the low WIDTH-1 bits differ by at most 1 as unsigned integers; without it, REQ-023 applies exactly.

Structure
REQ-027 SHALL place field widths (SIGN/EXP/MANT), state enum and compare function in package fp_chk_pkg.
REQ-028 SHALL instantiate one sub-module fp_chk_fifo (synchronous FIFO, flush input, full/empty flags).

Verification
REQ-029 SHALL cover: total=4, push 4 expected, 4 matching results -> pass_cnt=4, fail_cnt=0, done=1, fail_seen=0.
REQ-030 SHALL cover: total=3, third result 0x0400001 vs expected 0x0400000 -> fail_cnt=1, first_fail_idx=2, first_fail_got=0x0400001; with FP_CHK_ULP_TOL_EN -> pass_cnt=3.
REQ-031 SHALL cover: fill 16 entries -> exp_ready=0; push+pop same cycle while full -> push refused, one entry freed.
REQ-032 SHALL cover: res_valid with FIFO empty -> underflow=1, counters unchanged; start with total=0 -> done next cycle.
REQ-033 SHALL cover: rst asserted mid-run after 2 results -> all outputs 0 immediately, IDLE; new start runs cleanly.
